// File: rtl/nt_pkg.sv
// Shared constants, masks, FSM state type and helpers for the neurotransmitter regulator.
// Accumulators are indexed CORT=0 .. SER=4 throughout.
package nt_pkg;

    localparam int NT_COUNT = 5;

    localparam logic [2:0] NT_CORT = 3'd0;
    localparam logic [2:0] NT_DOP  = 3'd1;
    localparam logic [2:0] NT_GABA = 3'd2;
    localparam logic [2:0] NT_NE   = 3'd3;
    localparam logic [2:0] NT_SER  = 3'd4;

    localparam logic [7:0] STEP         = 8'd4;
    localparam logic [7:0] BASE         = 8'h40;
    localparam logic [7:0] DRIFT_AWAKE  = 8'd1;
    localparam logic [7:0] DRIFT_ASLEEP = 8'd4;

    localparam logic [15:0] SLEEP_PASS_MASK = 16'h1800;
    localparam int          QUANT_MSB       = 7;

    // Element k belongs to accumulator k (element 0 is CORT).
    localparam logic [4:0][15:0] EXC_MASK = {16'h000C, 16'hC000, 16'h0003, 16'h0030, 16'h3800};
    localparam logic [4:0][15:0] INH_MASK = {16'h1800, 16'h2000, 16'h4000, 16'h1800, 16'h0003};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_COMMIT
    } state_t;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'd0, v[i]};
        end
        return cnt;
    endfunction

    function automatic logic [9:0] quantize(input logic [4:0][7:0] acc);
        logic [9:0] q;
        q = 10'd0;
        for (int i = 0; i < NT_COUNT; i++) begin
            q[2*i +: 2] = acc[i][QUANT_MSB -: 2];
        end
        return q;
    endfunction

endpackage

// File: rtl/nt_update_alu.sv
// Shared combinational update for one accumulator: masked popcounts, signed step,
// saturation to 0..255 and drift back toward the resting value.
module nt_update_alu
    import nt_pkg::*;
(
    input  logic [7:0]  acc_in,
    input  logic [15:0] stim,
    input  logic        asleep,
    input  logic [2:0]  idx,
    output logic [7:0]  acc_out
);

    logic [15:0]        s;
    logic [15:0]        exc;
    logic [15:0]        inh;
    logic [4:0]         inc;
    logic [4:0]         dec;
    logic signed [10:0] delta;
    logic signed [10:0] sum;
    logic [7:0]         clamped;
    logic [7:0]         drift;

    always_comb begin
        s   = asleep ? (stim & SLEEP_PASS_MASK) : stim;
        exc = 16'd0;
        inh = 16'd0;
        if (idx <= NT_SER) begin
            exc = EXC_MASK[idx];
            inh = INH_MASK[idx];
        end
        inc = popcount16(s & exc);
        dec = popcount16(s & inh);

        // 11-bit signed headroom covers 255 + 16*STEP and 0 - 16*STEP without wrap.
        delta = ($signed({6'd0, inc}) - $signed({6'd0, dec})) * $signed({3'd0, STEP});
        sum   = $signed({3'd0, acc_in}) + delta;

        if (sum < 11'sd0) begin
            clamped = 8'd0;
        end else if (sum > 11'sd255) begin
            clamped = 8'd255;
        end else begin
            clamped = sum[7:0];
        end

        drift   = asleep ? DRIFT_ASLEEP : DRIFT_AWAKE;
        acc_out = clamped;
        if (clamped > BASE) begin
            acc_out = ((clamped - BASE) > drift) ? (clamped - drift) : BASE;
        end else if (clamped < BASE) begin
            acc_out = ((BASE - clamped) > drift) ? (clamped + drift) : BASE;
        end
    end

endmodule

// File: rtl/neurotransmitter_regulator.sv
// Tick-driven sweep over five saturating neurotransmitter accumulators using one shared
// update ALU, committing a quantized 2-bit-per-channel level bus once per sweep.
module neurotransmitter_regulator
    import nt_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [15:0] stimuli,
    input  logic [7:0]  action,
    output logic [9:0]  neurotransmitter_level,
    output logic        level_valid,
    output logic        busy,
    output logic        tick_overrun
);

    state_t          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic            pending_q, pending_d;
    logic [15:0]     snap_stim_q, snap_stim_d;
    logic            snap_asleep_q, snap_asleep_d;
    logic [4:0][7:0] acc_q, acc_d;
    logic [9:0]      level_q, level_d;
    logic            level_valid_q, level_valid_d;
    logic            tick_overrun_q, tick_overrun_d;
    logic [7:0]      alu_out;

    nt_update_alu u_alu (
        .acc_in  (acc_q[idx_q]),
        .stim    (snap_stim_q),
        .asleep  (snap_asleep_q),
        .idx     (idx_q),
        .acc_out (alu_out)
    );

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        pending_d      = pending_q;
        snap_stim_d    = snap_stim_q;
        snap_asleep_d  = snap_asleep_q;
        acc_d          = acc_q;
        level_d        = level_q;
        level_valid_d  = 1'b0;
        tick_overrun_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A tick queued on the commit edge starts here; a coincident new tick stays queued.
                if (tick || pending_q) begin
                    snap_stim_d   = stimuli;
                    snap_asleep_d = action[0];
                    idx_d         = NT_CORT;
                    state_d       = ST_SWEEP;
                    pending_d     = pending_q & tick;
                end
            end
            ST_SWEEP: begin
                acc_d[idx_q] = alu_out;
                if (idx_q == NT_SER) begin
                    state_d = ST_COMMIT;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
                if (tick) begin
                    if (pending_q) begin
                        tick_overrun_d = 1'b1;
                    end else begin
                        pending_d = 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                level_d       = quantize(acc_q);
                level_valid_d = 1'b1;
                if (pending_q) begin
                    pending_d     = 1'b0;
                    snap_stim_d   = stimuli;
                    snap_asleep_d = action[0];
                    idx_d         = NT_CORT;
                    state_d       = ST_SWEEP;
                    if (tick) begin
                        tick_overrun_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                    if (tick) begin
                        pending_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            idx_q          <= NT_CORT;
            pending_q      <= 1'b0;
            snap_stim_q    <= 16'd0;
            snap_asleep_q  <= 1'b0;
            acc_q          <= {NT_COUNT{BASE}};
            level_q        <= 10'h155;
            level_valid_q  <= 1'b0;
            tick_overrun_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            pending_q      <= pending_d;
            snap_stim_q    <= snap_stim_d;
            snap_asleep_q  <= snap_asleep_d;
            acc_q          <= acc_d;
            level_q        <= level_d;
            level_valid_q  <= level_valid_d;
            tick_overrun_q <= tick_overrun_d;
        end
    end

    assign neurotransmitter_level = level_q;
    assign level_valid            = level_valid_q;
    assign tick_overrun           = tick_overrun_q;
    assign busy                   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_neurotransmitter_regulator.sv
// Directed self-checking bench for neurotransmitter_regulator: hand-computed accumulator,
// level, latency, overrun and mid-sweep reset expectations.
module tb_neurotransmitter_regulator;

    logic        clk;
    logic        rst;
    logic        tick;
    logic [15:0] stimuli;
    logic [7:0]  action;
    logic [9:0]  neurotransmitter_level;
    logic        level_valid;
    logic        busy;
    logic        tick_overrun;

    int checkCount;
    int passCount;

    neurotransmitter_regulator dut (
        .clk                    (clk),
        .rst                    (rst),
        .tick                   (tick),
        .stimuli                (stimuli),
        .action                 (action),
        .neurotransmitter_level (neurotransmitter_level),
        .level_valid            (level_valid),
        .busy                   (busy),
        .tick_overrun           (tick_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // One tick, then 12 observed edges; inputs are scrambled after the tick edge so the
    // snapshot is what must be used.
    task automatic applyStimulus(input logic [15:0] stim, input logic [7:0] act,
                                 output int validEdge, output int validCount, output int busyCycles);
        stimuli    = stim;
        action     = act;
        tick       = 1'b1;
        validEdge  = -1;
        validCount = 0;
        busyCycles = 0;
        for (int e = 0; e < 12; e++) begin
            stepCycle();
            if (e == 0) begin
                tick    = 1'b0;
                stimuli = ~stim;
                action  = ~act;
            end
            if (busy) busyCycles++;
            if (level_valid) begin
                validCount++;
                if (validEdge < 0) validEdge = e;
            end
        end
    endtask

    initial begin
        int vEdge, vCnt, bCyc;
        int validSeen, busySeen, overrunCnt, firstValid, secondValid;

        checkCount = 0;
        passCount  = 0;
        rst        = 1'b1;
        tick       = 1'b0;
        stimuli    = 16'h0000;
        action     = 8'h00;

        repeat (3) stepCycle();
        checkOutput("reset_level", 32'(neurotransmitter_level), 32'h155);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        validSeen = 0;
        busySeen  = 0;
        for (int i = 0; i < 8; i++) begin
            stepCycle();
            if (level_valid) validSeen++;
            if (busy) busySeen++;
        end
        checkOutput("idle_no_valid", 32'(validSeen), 32'd0);
        checkOutput("idle_no_busy", 32'(busySeen), 32'd0);
        checkOutput("idle_level", 32'(neurotransmitter_level), 32'h155);

        applyStimulus(16'h0000, 8'h00, vEdge, vCnt, bCyc);
        checkOutput("zero_busy_cycles", 32'(bCyc), 32'd6);
        checkOutput("zero_valid_edge", 32'(vEdge), 32'd6);
        checkOutput("zero_valid_count", 32'(vCnt), 32'd1);
        checkOutput("zero_level", 32'(neurotransmitter_level), 32'h155);

        applyStimulus(16'h3800, 8'h00, vEdge, vCnt, bCyc);
        checkOutput("s3800_cort", 32'(dut.acc_q[0]), 32'h4B);
        checkOutput("s3800_dop", 32'(dut.acc_q[1]), 32'h39);
        checkOutput("s3800_gaba", 32'(dut.acc_q[2]), 32'h40);
        checkOutput("s3800_ne", 32'(dut.acc_q[3]), 32'h3D);
        checkOutput("s3800_ser", 32'(dut.acc_q[4]), 32'h39);
        checkOutput("s3800_level", 32'(neurotransmitter_level), 32'h011);
        for (int i = 0; i < 5; i++) applyStimulus(16'h3800, 8'h00, vEdge, vCnt, bCyc);
        checkOutput("s3800x6_cort", 32'(dut.acc_q[0]), 32'h82);
        checkOutput("s3800x6_level_cort", 32'(neurotransmitter_level[1:0]), 32'h2);

        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        stepCycle();
        applyStimulus(16'hC000, 8'h00, vEdge, vCnt, bCyc);
        checkOutput("sC000_ne_first", 32'(dut.acc_q[3]), 32'h47);
        checkOutput("sC000_gaba_first", 32'(dut.acc_q[2]), 32'h3D);
        for (int i = 0; i < 39; i++) applyStimulus(16'hC000, 8'h00, vEdge, vCnt, bCyc);
        checkOutput("sC000_ne_settled", 32'(dut.acc_q[3]), 32'hFE);
        checkOutput("sC000_gaba_floor", 32'(dut.acc_q[2]), 32'h01);
        checkOutput("sC000_level_ne", 32'(neurotransmitter_level[7:6]), 32'h3);
        checkOutput("sC000_level", 32'(neurotransmitter_level), 32'h1C5);

        applyStimulus(16'hC800, 8'h01, vEdge, vCnt, bCyc);
        checkOutput("sleep_ne", 32'(dut.acc_q[3]), 32'hFA);
        checkOutput("sleep_cort", 32'(dut.acc_q[0]), 32'h40);
        checkOutput("sleep_dop", 32'(dut.acc_q[1]), 32'h40);
        checkOutput("sleep_gaba", 32'(dut.acc_q[2]), 32'h05);
        checkOutput("sleep_level", 32'(neurotransmitter_level), 32'h1C5);

        // Ticks on edges 0, 2 and 3 of a sweep.
        stimuli     = 16'h0000;
        action      = 8'h00;
        overrunCnt  = 0;
        firstValid  = -1;
        secondValid = -1;
        for (int e = 0; e < 16; e++) begin
            tick = (e == 0 || e == 2 || e == 3);
            stepCycle();
            if (e == 2) checkOutput("ovr_not_yet", 32'(tick_overrun), 32'd0);
            if (e == 3) checkOutput("ovr_pulse", 32'(tick_overrun), 32'd1);
            if (tick_overrun) overrunCnt++;
            if (level_valid) begin
                if (firstValid < 0) firstValid = e;
                else if (secondValid < 0) secondValid = e;
            end
        end
        tick = 1'b0;
        checkOutput("ovr_count", 32'(overrunCnt), 32'd1);
        checkOutput("ovr_valid_first", 32'(firstValid), 32'd6);
        checkOutput("ovr_valid_second", 32'(secondValid), 32'd12);
        checkOutput("pre_reset_level", 32'(neurotransmitter_level), 32'h1C5);

        tick = 1'b1;
        stepCycle();
        tick = 1'b0;
        repeat (3) stepCycle();
        checkOutput("mid_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_level", 32'(neurotransmitter_level), 32'h155);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_ne", 32'(dut.acc_q[3]), 32'h40);
        stepCycle();
        rst = 1'b0;
        validSeen = 0;
        busySeen  = 0;
        for (int i = 0; i < 10; i++) begin
            stepCycle();
            if (level_valid) validSeen++;
            if (busy) busySeen++;
        end
        checkOutput("post_rst_no_valid", 32'(validSeen), 32'd0);
        checkOutput("post_rst_no_busy", 32'(busySeen), 32'd0);
        checkOutput("post_rst_level", 32'(neurotransmitter_level), 32'h155);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
